// File: rtl/fir_out_pkg.sv
// Shared constants and helpers for the FIR output serializer slice.
package fir_out_pkg;

    localparam int N_LANES = 4;
    localparam int LANE_W  = 2;

    // Right-shift that drops the fractional bits between FIR and DAC widths.
    function automatic int shift_amt(input int nb_in, input int nb_out);
        return nb_in - nb_out;
    endfunction

endpackage

// File: rtl/fir_out_requant.sv
// Round-half-up and saturate one signed FIR sample to the output width.
// Purely combinational; the top instantiates one per lane on the write side.
module fir_out_requant
    import fir_out_pkg::*;
#(
    parameter int NB_DATA_IN  = 19,
    parameter int NB_DATA_OUT = 12
) (
    input  logic [NB_DATA_IN-1:0]  x,
    output logic [NB_DATA_OUT-1:0] y,
    output logic                   clamp
);

    localparam int S = shift_amt(NB_DATA_IN, NB_DATA_OUT);

    // Half an output LSB, expressed in the one-bit-extended input domain.
    localparam logic [NB_DATA_IN:0] RND = {{NB_DATA_IN{1'b0}}, 1'b1} << (S - 1);

    localparam logic [NB_DATA_OUT-1:0] MAX_V = {1'b0, {(NB_DATA_OUT-1){1'b1}}};
    localparam logic [NB_DATA_OUT-1:0] MIN_V = {1'b1, {(NB_DATA_OUT-1){1'b0}}};

    logic [NB_DATA_IN:0]  x_ext_s;
    logic [NB_DATA_IN:0]  sum_s;
    logic [NB_DATA_OUT:0] y_wide_s;
    logic                 unused_lsb_s;

    // The extra sign bit means adding the rounding constant can never wrap.
    assign x_ext_s  = {x[NB_DATA_IN-1], x};
    assign sum_s    = x_ext_s + RND;
    // Taking the upper bits is the arithmetic shift by S (floor).
    assign y_wide_s = sum_s[NB_DATA_IN:S];
    // Fractional bits are discarded by design.
    assign unused_lsb_s = ^sum_s[S-1:0];

    // Clamp when the two top bits of the widened result disagree.
    always_comb begin
        y     = y_wide_s[NB_DATA_OUT-1:0];
        clamp = 1'b0;
        if (y_wide_s[NB_DATA_OUT] != y_wide_s[NB_DATA_OUT-1]) begin
            clamp = 1'b1;
            y     = y_wide_s[NB_DATA_OUT] ? MIN_V : MAX_V;
        end else begin
            clamp = 1'b0;
            y     = y_wide_s[NB_DATA_OUT-1:0];
        end
    end

endmodule

// File: rtl/fir_out_serializer.sv
// Accepts 4-lane requantized FIR blocks into a 2-entry block FIFO and
// streams them out one sample per handshake, lane 0 first.
module fir_out_serializer
    import fir_out_pkg::*;
#(
    parameter int NB_DATA_IN  = 19,
    parameter int NB_DATA_OUT = 12
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic [NB_DATA_IN-1:0]  i_data_0,
    input  logic [NB_DATA_IN-1:0]  i_data_1,
    input  logic [NB_DATA_IN-1:0]  i_data_2,
    input  logic [NB_DATA_IN-1:0]  i_data_3,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [NB_DATA_OUT-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [LANE_W-1:0]      o_lane,
    output logic                   o_last,
    output logic                   o_sat,
    input  logic                   i_clear_sat
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

    // Block storage: two entries of four output-width samples.
    logic [NB_DATA_OUT-1:0] buf_r [0:1][0:N_LANES-1];

    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic [LANE_W-1:0] lane_r;
    logic              sat_r;

    logic              wr_ptr_nxt_s;
    logic              rd_ptr_nxt_s;
    logic [1:0]        count_nxt_s;
    logic [LANE_W-1:0] lane_nxt_s;
    logic              sat_nxt_s;

    logic                   push_s;
    logic                   pop_s;
    logic                   release_s;
    logic                   valid_s;
    logic                   ready_s;
    logic [NB_DATA_IN-1:0]  din_s   [0:N_LANES-1];
    logic [NB_DATA_OUT-1:0] req_s   [0:N_LANES-1];
    logic [N_LANES-1:0]     clamp_s;

    assign din_s[0] = i_data_0;
    assign din_s[1] = i_data_1;
    assign din_s[2] = i_data_2;
    assign din_s[3] = i_data_3;

    for (genvar g = 0; g < N_LANES; g++) begin : g_req
        fir_out_requant #(
            .NB_DATA_IN  (NB_DATA_IN),
            .NB_DATA_OUT (NB_DATA_OUT)
        ) u_requant (
            .x     (din_s[g]),
            .y     (req_s[g]),
            .clamp (clamp_s[g])
        );
    end

    // Handshake decode; readiness comes only from the registered count so a
    // release in the same cycle never opens the input early.
    assign ready_s   = (count_r != 2'd2);
    assign valid_s   = (count_r != 2'd0);
    assign push_s    = i_valid && ready_s;
    assign pop_s     = valid_s && i_ready;
    assign release_s = pop_s && (lane_r == LAST_LANE);

    // Next-state for count, pointers, lane counter and sticky saturation.
    always_comb begin
        count_nxt_s  = count_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        lane_nxt_s   = lane_r;
        sat_nxt_s    = sat_r;

        case ({push_s, release_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase

        if (push_s) begin
            wr_ptr_nxt_s = ~wr_ptr_r;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (release_s) begin
            rd_ptr_nxt_s = ~rd_ptr_r;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        // Lane counter wraps 3 -> 0 naturally at its 2-bit width.
        if (pop_s) begin
            lane_nxt_s = lane_r + 2'd1;
        end else begin
            lane_nxt_s = lane_r;
        end

        // A clamping push takes priority over a clear in the same cycle.
        if (push_s && (|clamp_s)) begin
            sat_nxt_s = 1'b1;
        end else if (i_clear_sat) begin
            sat_nxt_s = 1'b0;
        end else begin
            sat_nxt_s = sat_r;
        end
    end

    // Control state registers; reset drops any buffered blocks at once.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            lane_r   <= {LANE_W{1'b0}};
            sat_r    <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            lane_r   <= lane_nxt_s;
            sat_r    <= sat_nxt_s;
        end
    end

    // Sample storage is data-path only; its content is meaningless until pushed.
    always_ff @(posedge clock) begin
        if (push_s) begin
            for (int l = 0; l < N_LANES; l++) begin
                buf_r[wr_ptr_r][l] <= req_s[l];
            end
        end
    end

    assign o_ready = ready_s;
    assign o_valid = valid_s;
    assign o_data  = buf_r[rd_ptr_r][lane_r];
    assign o_lane  = lane_r;
    assign o_last  = valid_s && (lane_r == LAST_LANE);
    assign o_sat   = sat_r;

endmodule

// File: tb/tb_fir_out_serializer.sv
// Scoreboard bench for fir_out_serializer: drivers push expected samples
// into a queue, a negedge monitor pops and compares on every output handshake.
module tb_fir_out_serializer;

    localparam int NB_IN  = 19;
    localparam int NB_OUT = 12;

    typedef int blk_t [4];
    typedef struct {
        int data;
        int lane;
        int last;
    } exp_t;

    logic              clock;
    logic              i_reset;
    logic [NB_IN-1:0]  i_data_0, i_data_1, i_data_2, i_data_3;
    logic              i_valid;
    logic              o_ready;
    logic [NB_OUT-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic [1:0]        o_lane;
    logic              o_last;
    logic              o_sat;
    logic              i_clear_sat;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    bit   rand_on;

    fir_out_serializer #(.NB_DATA_IN(NB_IN), .NB_DATA_OUT(NB_OUT)) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_data_0    (i_data_0),
        .i_data_1    (i_data_1),
        .i_data_2    (i_data_2),
        .i_data_3    (i_data_3),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_lane      (o_lane),
        .o_last      (o_last),
        .o_sat       (o_sat),
        .i_clear_sat (i_clear_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Independent reference: integer floor-shift rounding then clamp.
    function automatic int model(input int x);
        int s, t, hi, lo;
        s  = NB_IN - NB_OUT;
        t  = (x + (1 <<< (s - 1))) >>> s;
        hi = (1 <<< (NB_OUT - 1)) - 1;
        lo = -(1 <<< (NB_OUT - 1));
        if (t > hi) t = hi;
        if (t < lo) t = lo;
        return t;
    endfunction

    task automatic drive_data(input blk_t d);
        int v;
        v = d[0]; i_data_0 = v[NB_IN-1:0];
        v = d[1]; i_data_1 = v[NB_IN-1:0];
        v = d[2]; i_data_2 = v[NB_IN-1:0];
        v = d[3]; i_data_3 = v[NB_IN-1:0];
    endtask

    // Present a block, wait (bounded) for o_ready, then record its samples.
    task automatic send_block(input blk_t d, input blk_t e);
        int w;
        exp_t it;
        drive_data(d);
        i_valid = 1'b1;
        w = 0;
        while (!o_ready && w < 200) begin
            step();
            w++;
        end
        if (!o_ready) begin
            chk("push_timeout", 0, 1);
        end else begin
            for (int l = 0; l < 4; l++) begin
                it.data = e[l];
                it.lane = l;
                it.last = (l == 3) ? 1 : 0;
                sb_q.push_back(it);
            end
            step();
        end
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 400) begin
            step();
            w++;
        end
        chk("drain_left", sb_q.size(), 0);
    endtask

    // Monitor: every accepted output sample must match the scoreboard head.
    always @(negedge clock) begin
        exp_t it;
        if (!i_reset && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_sample", 1, 0);
            end else begin
                it = sb_q.pop_front();
                chk("o_data", int'($signed(o_data)), it.data);
                chk("o_lane", int'(o_lane), it.lane);
                chk("o_last", int'(o_last), it.last);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t d, e;
        i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_clear_sat = 1'b0;
        i_data_0 = '0; i_data_1 = '0; i_data_2 = '0; i_data_3 = '0;
        rand_on = 1'b0;
        #1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_lane",  int'(o_lane), 0);
        chk("rst_last",  int'(o_last), 0);
        chk("rst_sat",   int'(o_sat), 0);
        step(); step();
        i_reset = 1'b0;
        step();

        // Basic rounding block, sink always ready.
        i_ready = 1'b1;
        send_block('{64, 63, -64, -65}, '{1, 0, 0, -1});
        chk("lat_valid", int'(o_valid), 1);
        chk("lat_lane0", int'(o_lane), 0);
        chk("basic_sat", int'(o_sat), 0);
        drain();

        // Saturation block and sticky flag clear.
        send_block('{262143, -262144, 8191, -8257}, '{2047, -2048, 64, -65});
        chk("sat_set", int'(o_sat), 1);
        drain();
        chk("sat_hold", int'(o_sat), 1);
        i_clear_sat = 1'b1;
        step();
        i_clear_sat = 1'b0;
        chk("sat_clear", int'(o_sat), 0);

        // Backpressure: two blocks fill the FIFO, a third is refused.
        i_ready = 1'b0;
        send_block('{128, 256, 384, 512}, '{1, 2, 3, 4});
        send_block('{-128, -256, -384, -512}, '{-1, -2, -3, -4});
        chk("full_ready", int'(o_ready), 0);
        drive_data('{640, 768, 896, 1024});
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_ready", int'(o_ready), 0);
            chk("bp_valid", int'(o_valid), 1);
            chk("bp_lane", int'(o_lane), 0);
            chk("bp_data", int'($signed(o_data)), 1);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_ready_low", int'(o_ready), 0);
        end
        step();
        chk("bp_ready_rise", int'(o_ready), 1);
        drain();
        chk("empty_valid", int'(o_valid), 0);

        // Reset mid-block with two blocks buffered.
        i_ready = 1'b0;
        send_block('{1280, 1408, 1536, 1664}, '{10, 11, 12, 13});
        send_block('{1792, 1920, 2048, 2176}, '{14, 15, 16, 17});
        i_ready = 1'b1;
        step(); step();
        i_ready = 1'b0;
        chk("pre_rst_lane", int'(o_lane), 2);
        #1;
        i_reset = 1'b1;
        sb_q.delete();
        #1;
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_ready", int'(o_ready), 1);
        chk("mid_rst_lane", int'(o_lane), 0);
        step();
        i_reset = 1'b0;
        step();
        chk("post_rst_valid", int'(o_valid), 0);
        i_ready = 1'b1;
        send_block('{128, -128, 256, -256}, '{1, -1, 2, -2});
        chk("post_rst_lane", int'(o_lane), 0);
        chk("post_rst_data", int'($signed(o_data)), 1);
        drain();

        // Random traffic against the reference model.
        rand_on = 1'b1;
        fork
            begin
                for (int b = 0; b < 150; b++) begin
                    for (int l = 0; l < 4; l++) begin
                        logic [NB_IN-1:0] r;
                        r = NB_IN'($urandom);
                        if ($urandom_range(0, 1) == 0) d[l] = int'($signed(r));
                        else d[l] = int'($urandom_range(0, 4000)) - 2000;
                        e[l] = model(d[l]);
                    end
                    send_block(d, e);
                    repeat ($urandom_range(0, 2)) step();
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    i_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
            end
        join
        i_ready = 1'b1;
        drain();
        chk("final_valid", int'(o_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
